difference_extract: RTL and testbench
=====================================

// Module: difference_extract
// PURPOSE
//  Inverse of the board-level accumulate datapath. On each debounced KEY press, captures SW.
//  It outputs the difference between that capture and the previous one, so a running total
//  entered on SW is turned back into per-press increments.
//  Sits under a board Top: Clock<-CLOCK_50, Key_n<-KEY[0], Data<-SW, Diff/Borrow->LEDR.
// PARAMETERS
//  WIDTH            10    data/difference width (matches SW/LEDR)
//  DEBOUNCE_CYCLES  16    consecutive stable synchronized samples to accept a key level (>=2)
// PORTS
//  Clock    in   1      single clock; all state changes on rising edge
//  Reset    in   1      synchronous, active-high reset
//  Key_n    in   1      raw pushbutton, active-low, asynchronous to Clock
//  Data     in   WIDTH  value captured on press (stable around press)
//  Diff     out  WIDTH  Data_capture - Prev_capture, two's-complement, mod 2^WIDTH
//  Borrow   out  1      1 when Data_capture < Prev_capture (unsigned compare)
//  Valid    out  1      one-cycle pulse when Diff/Borrow update
//  Count    out  4      presses accepted since reset, wraps 15->0
// BEHAVIOUR
//  Reset (sync, active-high):
//   - Diff=0, Borrow=0, Valid=0, Count=0; Prev=0; sync flops=1; debounced level=1; counter=0.
//   - FSM enters WAIT_RELEASE.
//  Synchronizer: two flops on Key_n; only the second flop's output (ks) is used.
//  Debounce:
//   - counter clears whenever ks == debounced level.
//   - counter increments while ks != debounced level.
//   - on reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
//  FSM (states in package):
//   - WAIT_RELEASE: go ARMED when debounced level == 1. A key held through reset is ignored
//     until released.
//   - ARMED: debounced level 1->0 asserts strobe for 1 cycle; go HELD.
//   - HELD: go ARMED when debounced level returns to 1. No further strobes while held.
//  Capture: the edge ending the strobe cycle registers:
//   - Diff <= Data - Prev
//   - Borrow <= (Data < Prev)
//   - Prev <= Data
//   - Count <= Count+1
//   - Valid <= 1
//  Valid is 0 on every other cycle. Diff/Borrow hold their value between presses.
//  Latency: Key_n low (stable) -> Valid = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  Glitches on Key_n shorter than DEBOUNCE_CYCLES samples produce no strobe.
//  Boundaries:
//   - First press after reset yields Diff=Data, Borrow=0.
//   - Equal captures yield Diff=0, Borrow=0.
//   - Count wraps 15->0 silently.
//   - Reset asserted mid-debounce or in HELD: pending press discarded, no Valid.
//     Outputs take reset values the next cycle.
//  Data is sampled directly (assumed static switches); no synchronizer on Data.
// STRUCTURE
//  Shared package diff_pkg:
//   - typedef enum logic [1:0] {WAIT_RELEASE, ARMED, HELD} press_state_t
//   - localparam default WIDTH=10
//  Sub-module key_debounce (Clock, Reset, Key_n -> level, fall_strobe): synchronizer + counter.
//  Top level holds the FSM, Prev, Diff/Borrow/Count registers.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset, Data=10'd25, clean press:
//     -> Valid pulse exactly 7 cycles after Key_n low; Diff=25, Borrow=0, Count=1.
//  2. Then Data=10'd40, press -> Diff=15, Borrow=0, Count=2.
//     Then Data=10'd5, press -> Diff=10'h3DD (-35), Borrow=1, Count=3.
//  3. Key_n low for 3 cycles then high (glitch) -> no Valid; Diff/Count unchanged.
//  4. Key_n held low 100 cycles -> exactly one Valid. Bounce on release (1-2 cycle pulses)
//     -> no extra Valid.
//  5. Key_n low across Reset deassertion -> no Valid until release and a new press;
//     then Diff=Data, Count=1.
//  6. 16 presses with Data=10'd1023 then 0 alternating:
//     -> Count returns to 0. Diffs alternate 1023/Borrow=0 and 1 (=0-1023 mod 1024)/Borrow=1;
//        first press Diff=1023.

Source files
------------

// File: rtl/difference_extract_pkg.sv
// Shared types and defaults for the difference_extract block: the press FSM
// state encoding and the default widths used by the top and its interface.
package diff_pkg;

    localparam int WIDTH_DEFAULT    = 10;
    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int COUNT_W          = 4;

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        ARMED        = 2'd1,
        HELD         = 2'd2
    } press_state_t;

endpackage

// File: rtl/difference_extract_if.sv
// Bundle of the board-facing signals of difference_extract.
// The master side (board / bench) drives the raw key and the switches; the
// slave side (the block) returns the difference, borrow, press pulse and count.
// State is a read-only view of the press FSM for observation.
// Handshake: there is no back-pressure. Valid is a one-cycle pulse that marks
// the cycle in which Diff/Borrow/Count have just been updated; the consumer
// must sample on that cycle, and the values then hold until the next pulse.
interface difference_extract_if
    import diff_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic               Key_n;
    logic [WIDTH-1:0]   Data;
    logic [WIDTH-1:0]   Diff;
    logic               Borrow;
    logic               Valid;
    logic [COUNT_W-1:0] Count;
    press_state_t       State;

    modport master (
        output Key_n,
        output Data,
        input  Diff,
        input  Borrow,
        input  Valid,
        input  Count,
        input  State
    );

    modport slave (
        input  Key_n,
        input  Data,
        output Diff,
        output Borrow,
        output Valid,
        output Count,
        output State
    );

endinterface

// File: rtl/difference_extract_key_debounce.sv
// Two-flop synchronizer plus stability counter for an active-low pushbutton.
// The debounced level only changes after DEBOUNCE_CYCLES consecutive
// synchronized samples disagree with it; fall_strobe pulses for one cycle
// right after the level drops from 1 to 0.
module key_debounce
    import diff_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Key_n,
    output logic level,
    output logic fall_strobe,
    output logic ks
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;

    // Count disagreeing samples; flip the level once the run is long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce state; reset assumes the key is released.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= Key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign level       = level_q;
    assign fall_strobe = fall_q;
    assign ks          = sync2_q;

endmodule

// File: rtl/difference_extract.sv
// Turns a running total entered on the switches back into per-press
// increments: each accepted key press captures Data and reports the
// difference from the previous capture, a borrow flag and a press count.
module difference_extract
    import diff_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input logic                 Clock,
    input logic                 Reset,
    difference_extract_if.slave bus
);

    // Reset forces the synchronizer and debounced level to "released" before
    // the pin has actually been sampled, so leaving WAIT_RELEASE needs a run of
    // high samples longer than the synchronizer depth. Otherwise a key held
    // through reset would be mistaken for a fresh press once it debounced low.
    localparam int REL_MAX_I = DEBOUNCE_CYCLES + 1;
    localparam int REL_W     = $clog2(REL_MAX_I + 1);
    localparam logic [REL_W-1:0] REL_MAX = REL_W'(REL_MAX_I);

    logic level;
    logic fall_strobe;
    logic ks;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .Clock       (Clock),
        .Reset       (Reset),
        .Key_n       (bus.Key_n),
        .level       (level),
        .fall_strobe (fall_strobe),
        .ks          (ks)
    );

    press_state_t       state_q;
    logic [REL_W-1:0]   rel_cnt_q;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;
    logic               valid_q;
    logic [COUNT_W-1:0] count_q;

    // Press FSM with capture registers; Valid is high only on the capture cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= WAIT_RELEASE;
            rel_cnt_q <= '0;
            prev_q    <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                WAIT_RELEASE: begin
                    if (level && ks) begin
                        if (rel_cnt_q == REL_MAX) begin
                            state_q   <= ARMED;
                            rel_cnt_q <= '0;
                        end else begin
                            rel_cnt_q <= rel_cnt_q + 1'b1;
                        end
                    end else begin
                        rel_cnt_q <= '0;
                    end
                end
                ARMED: begin
                    if (fall_strobe) begin
                        diff_q   <= bus.Data - prev_q;
                        borrow_q <= (bus.Data < prev_q);
                        prev_q   <= bus.Data;
                        count_q  <= count_q + 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= HELD;
                    end
                end
                HELD: begin
                    if (level) begin
                        state_q <= ARMED;
                    end
                end
                default: begin
                    state_q <= WAIT_RELEASE;
                end
            endcase
        end
    end

    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
    assign bus.Valid  = valid_q;
    assign bus.Count  = count_q;
    assign bus.State  = state_q;

endmodule

// File: tb/tb_difference_extract.sv
// Directed bench for difference_extract with DEBOUNCE_CYCLES=4.
module tb_difference_extract;
    import diff_pkg::*;

    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks   = 0;
    int n_fail     = 0;
    int valid_cnt  = 0;
    int v0;

    difference_extract_if #(.WIDTH(W)) bus ();

    difference_extract #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // clock
    always #5 clk = ~clk;

    // count every Valid pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.Valid === 1'b1) valid_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [W-1:0] d, input int hold);
        bus.Data  = d;
        bus.Key_n = 1'b0;
        tick(hold);
        bus.Key_n = 1'b1;
        tick(12);
    endtask

    initial begin
        bus.Key_n = 1'b1;
        bus.Data  = '0;

        // reset state
        tick(3);
        check("rst_diff",   32'(bus.Diff),   32'd0);
        check("rst_borrow", 32'(bus.Borrow), 32'd0);
        check("rst_valid",  32'(bus.Valid),  32'd0);
        check("rst_count",  32'(bus.Count),  32'd0);
        check("rst_state",  32'(bus.State),  32'(WAIT_RELEASE));
        rst = 1'b0;
        tick(20);
        check("armed_after_reset", 32'(bus.State), 32'(ARMED));

        // 1: first press, exact latency of 7 cycles
        v0 = valid_cnt;
        bus.Data  = 10'd25;
        bus.Key_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("t1_no_early_valid", 32'(bus.Valid), 32'd0);
        end
        tick(1);
        check("t1_valid_at_7", 32'(bus.Valid),  32'd1);
        check("t1_diff",       32'(bus.Diff),   32'd25);
        check("t1_borrow",     32'(bus.Borrow), 32'd0);
        check("t1_count",      32'(bus.Count),  32'd1);
        tick(1);
        check("t1_valid_one_cycle", 32'(bus.Valid), 32'd0);
        bus.Key_n = 1'b1;
        tick(12);
        check("t1_one_pulse", 32'(valid_cnt - v0), 32'd1);

        // 2: positive step then a step down with borrow
        press(10'd40, 12);
        check("t2a_diff",   32'(bus.Diff),   32'd15);
        check("t2a_borrow", 32'(bus.Borrow), 32'd0);
        check("t2a_count",  32'(bus.Count),  32'd2);
        press(10'd5, 12);
        check("t2b_diff",   32'(bus.Diff),   32'h3DD);
        check("t2b_borrow", 32'(bus.Borrow), 32'd1);
        check("t2b_count",  32'(bus.Count),  32'd3);

        // 3: 3-cycle glitch is rejected
        v0 = valid_cnt;
        bus.Data = 10'd500;
        press(10'd500, 3);
        check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t3_diff",     32'(bus.Diff),       32'h3DD);
        check("t3_count",    32'(bus.Count),      32'd3);

        // 4: long hold gives one pulse; release bounce gives none
        v0 = valid_cnt;
        bus.Data  = 10'd100;
        bus.Key_n = 1'b0;
        tick(100);
        check("t4_one_valid", 32'(valid_cnt - v0), 32'd1);
        check("t4_diff",      32'(bus.Diff),       32'd95);
        check("t4_borrow",    32'(bus.Borrow),     32'd0);
        check("t4_count",     32'(bus.Count),      32'd4);
        bus.Key_n = 1'b1; tick(1);
        bus.Key_n = 1'b0; tick(2);
        bus.Key_n = 1'b1; tick(2);
        bus.Key_n = 1'b0; tick(1);
        bus.Key_n = 1'b1; tick(12);
        check("t4_bounce_no_valid", 32'(valid_cnt - v0), 32'd1);
        check("t4_bounce_count",    32'(bus.Count),      32'd4);
        // equal capture
        press(10'd100, 12);
        check("t4_eq_diff",   32'(bus.Diff),   32'd0);
        check("t4_eq_borrow", 32'(bus.Borrow), 32'd0);
        check("t4_eq_count",  32'(bus.Count),  32'd5);

        // 5: reset mid-debounce, key held low across reset release
        v0 = valid_cnt;
        bus.Data  = 10'd77;
        bus.Key_n = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("t5_rst_diff",   32'(bus.Diff),   32'd0);
        check("t5_rst_borrow", 32'(bus.Borrow), 32'd0);
        check("t5_rst_valid",  32'(bus.Valid),  32'd0);
        check("t5_rst_count",  32'(bus.Count),  32'd0);
        check("t5_rst_state",  32'(bus.State),  32'(WAIT_RELEASE));
        tick(2);
        rst = 1'b0;
        tick(30);
        check("t5_held_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t5_held_state",    32'(bus.State),      32'(WAIT_RELEASE));
        check("t5_held_count",    32'(bus.Count),      32'd0);
        bus.Key_n = 1'b1;
        tick(20);
        check("t5_released_state", 32'(bus.State), 32'(ARMED));
        press(10'd77, 12);
        check("t5_diff",   32'(bus.Diff),   32'd77);
        check("t5_borrow", 32'(bus.Borrow), 32'd0);
        check("t5_count",  32'(bus.Count),  32'd1);

        // 6: 16 alternating presses, count wraps back to 0
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        for (int i = 0; i < 16; i++) begin
            press((i % 2 == 0) ? 10'd1023 : 10'd0, 12);
            check("t6_diff",   32'(bus.Diff),   (i % 2 == 0) ? 32'd1023 : 32'd1);
            check("t6_borrow", 32'(bus.Borrow), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("t6_count",  32'(bus.Count),  32'((i + 1) % 16));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
